muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- EX-stage multiply/divide unit of the P6 pipeline, parallel to the ALU.
- Runs mult/multu/div/divu over a fixed multi-cycle latency and holds the HI/LO registers.
- Services mthi/mtlo writes and provides HI/LO for mfhi/mflo.
- Its busy output, together with the EX-stage start, feeds the hazard solver, which stalls ID while a muldiv-class instruction is decoded and the unit is occupied.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (and madd family).
- DIV_CYCLES, 10, busy cycles for div/divu.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  EX instruction is a muldiv_C op (mult/multu/div/divu/madd family); qualified by valid.
- valid  input  1  EX slot holds a real (non-bubble) instruction.
- op  input  4  0000 none, 0001 mult, 0010 multu, 0011 div, 0100 divu, 0101 mthi, 0110 mtlo, 0111 madd, 1000 maddu, 1001 msub, 1010 msubu.
- A  input  32  forwarded rs value.
- B  input  32  forwarded rt value.
- busy  output  1  computation in progress.
- HI  output  32  HI register.
- LO  output  32  LO register.

Behaviour:
- Reset (async, reset_n=0):
  - HI=0, LO=0, busy=0.
  - Counter=0, state IDLE, pending result regs cleared.
  - Reset mid-operation aborts the computation; no commit occurs.
- States: IDLE, RUN.
- Launch, IDLE with start&valid and op in {mult, multu, div, divu, madd family} at edge T0:
  - Result is computed combinationally from A/B/HI/LO and latched into pending regs.
  - Counter loads MULT_CYCLES or DIV_CYCLES; go to RUN.
  - busy=1 from T0+1.
- RUN:
  - Counter decrements each edge.
  - At the edge where it reaches 0 (T0+MULT_CYCLES or T0+DIV_CYCLES), pending is committed to HI/LO, busy drops to 0 at that same edge, and the state returns to IDLE.
  - busy is therefore high for exactly N cycles.
- mult: {HI,LO} = signed A × signed B, full 64 bits.
- multu: {HI,LO} = unsigned A × unsigned B.
- div:
  - LO = quotient truncated toward zero; HI = remainder, sign of dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: unsigned quotient and remainder.
- Divide by zero: still busy DIV_CYCLES; HI/LO unchanged at commit.
- mthi/mtlo, IDLE with valid:
  - Write HI (or LO) = A at the next edge, no busy.
  - The other register is unchanged.
- Ignored requests:
  - Any start or mthi/mtlo while busy=1 is ignored; the hazard solver guarantees this never occurs, and the bench asserts it.
  - start with valid=0, or op=none, causes no action.
- Read timing: HI/LO outputs are pure register outputs, so mfhi/mflo read the committed values; no internal forwarding.
- Back-to-back ops: a new start is accepted in the cycle after busy falls, sampling the updated HI/LO.

Optional Feature:
- Macro: MULDIV_MADD_EN.
- Defined:
  - op 0111–1010 launch with MULT_CYCLES latency.
  - madd: {HI,LO} += signed A×B.
  - maddu: unsigned accumulate.
  - msub/msubu: {HI,LO} -= product.
  - Accumulation is mod 2^64 and uses HI/LO as sampled at launch.
- Not defined: op 0111–1010 are treated as op=none; no state change, busy stays 0.

Test Plan:
- Reset then mult A=0xFFFFFFFE(-2), B=3 at T0 -> busy=1 for T0+1..T0+5 inclusive; after edge T0+5, HI=0xFFFFFFFF, LO=0xFFFFFFFA, busy=0.
- multu A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- div A=0xFFFFFFF9(-7), B=2 -> busy 10 cycles; LO=0xFFFFFFFD(-3), HI=0xFFFFFFFF(-1). Then divu A=7, B=0 -> busy 10 cycles; HI/LO unchanged.
- mthi A=0x12345678, then mtlo A=0x9ABCDEF0 on consecutive cycles -> HI/LO updated the next edge each; busy stays 0. Then start div while busy with mtlo asserted on the following cycle -> mtlo ignored, LO equals the div result.
- Launch mult, pull reset_n low at T0+3 -> busy=0 and HI=LO=0 immediately (asynchronous); no later commit after release.
- With MULDIV_MADD_EN: HI=0, LO=0xFFFFFFFF, madd A=1, B=1 -> HI=1, LO=0 after 5 cycles. Without the macro, the same stimulus leaves HI/LO unchanged and busy=0.

Source files
------------

// File: rtl/muldiv_unit.sv
// EX-stage multiply/divide unit holding HI/LO; results are latched at launch and committed after a fixed latency.
// Optional multiply-accumulate ops (madd/maddu/msub/msubu) are enabled by defining MULDIV_MADD_EN.
module muldiv_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        valid,
    input  logic [3:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [3:0] OP_MULT  = 4'b0001;
    localparam logic [3:0] OP_MULTU = 4'b0010;
    localparam logic [3:0] OP_DIV   = 4'b0011;
    localparam logic [3:0] OP_DIVU  = 4'b0100;
    localparam logic [3:0] OP_MTHI  = 4'b0101;
    localparam logic [3:0] OP_MTLO  = 4'b0110;
`ifdef MULDIV_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'b0111;
    localparam logic [3:0] OP_MADDU = 4'b1000;
    localparam logic [3:0] OP_MSUB  = 4'b1001;
    localparam logic [3:0] OP_MSUBU = 4'b1010;
`endif

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [63:0]   pend_q, pend_d;

    logic signed [63:0] a_sx, b_sx, prod_s;
    logic        [63:0] prod_u;
    logic signed [32:0] a33, b33, quo33, rem33;
    logic        [31:0] b_u, quo_u, rem_u;
    logic        [63:0] hilo;

    // 33-bit signed divide makes 0x80000000 / -1 produce 0x80000000 without a special case
    assign a_sx   = {{32{A[31]}}, A};
    assign b_sx   = {{32{B[31]}}, B};
    assign prod_s = a_sx * b_sx;
    assign prod_u = {32'b0, A} * {32'b0, B};
    assign a33    = {A[31], A};
    assign b33    = (B == 32'b0) ? 33'sd1 : {B[31], B};
    assign quo33  = a33 / b33;
    assign rem33  = a33 % b33;
    assign b_u    = (B == 32'b0) ? 32'd1 : B;
    assign quo_u  = A / b_u;
    assign rem_u  = A % b_u;
    assign hilo   = {hi_q, lo_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        pend_d  = pend_q;
        case (state_q)
            IDLE: begin
                if (valid && op == OP_MTHI) hi_d = A;
                if (valid && op == OP_MTLO) lo_d = A;
                if (valid && start) begin
                    case (op)
                        OP_MULT: begin
                            pend_d  = prod_s;
                            cnt_d   = CW'(MULT_CYCLES);
                            state_d = RUN;
                        end
                        OP_MULTU: begin
                            pend_d  = prod_u;
                            cnt_d   = CW'(MULT_CYCLES);
                            state_d = RUN;
                        end
                        OP_DIV: begin
                            pend_d  = (B == 32'b0) ? hilo : {rem33[31:0], quo33[31:0]};
                            cnt_d   = CW'(DIV_CYCLES);
                            state_d = RUN;
                        end
                        OP_DIVU: begin
                            pend_d  = (B == 32'b0) ? hilo : {rem_u, quo_u};
                            cnt_d   = CW'(DIV_CYCLES);
                            state_d = RUN;
                        end
`ifdef MULDIV_MADD_EN
                        OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                            case (op)
                                OP_MADD:  pend_d = hilo + prod_s;
                                OP_MADDU: pend_d = hilo + prod_u;
                                OP_MSUB:  pend_d = hilo - prod_s;
                                default:  pend_d = hilo - prod_u;
                            endcase
                            cnt_d   = CW'(MULT_CYCLES);
                            state_d = RUN;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            RUN: begin
                // Requests arriving while busy are dropped; only the countdown advances
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    hi_d    = pend_q[63:32];
                    lo_d    = pend_q[31:0];
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            pend_q  <= pend_d;
        end
    end

    assign busy = (state_q == RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed plan steps plus random ops against an arithmetic reference model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        valid;
    logic [3:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } res_t;

    muldiv_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .valid   (valid),
        .op      (op),
        .A       (A),
        .B       (B),
        .busy    (busy),
        .HI      (HI),
        .LO      (LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Architectural meaning of each op: new HI/LO and how long busy stays high
    function automatic res_t model(input bit st, input bit vl, input logic [3:0] o,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] hi, input logic [31:0] lo);
        res_t        r;
        int          sa;
        int          sb;
        longint      q;
        longint      rm;
        logic [63:0] p;
        logic [63:0] acc;
        r.hi = hi; r.lo = lo; r.lat = 0;
        sa = a; sb = b; acc = {hi, lo}; p = 64'd0;
        if (vl) begin
            if (o == 4'd5) r.hi = a;
            else if (o == 4'd6) r.lo = a;
            else if (st) begin
                case (o)
                    4'd1: begin p = longint'(sa) * longint'(sb); {r.hi, r.lo} = p; r.lat = 5; end
                    4'd2: begin p = {32'd0, a} * {32'd0, b}; {r.hi, r.lo} = p; r.lat = 5; end
                    4'd3: begin
                        r.lat = 10;
                        if (b != 32'd0) begin
                            q = longint'(sa) / longint'(sb);
                            rm = longint'(sa) % longint'(sb);
                            r.lo = q[31:0]; r.hi = rm[31:0];
                        end
                    end
                    4'd4: begin
                        r.lat = 10;
                        if (b != 32'd0) begin r.lo = a / b; r.hi = a % b; end
                    end
`ifdef MULDIV_MADD_EN
                    4'd7: begin p = longint'(sa) * longint'(sb); {r.hi, r.lo} = acc + p; r.lat = 5; end
                    4'd8: begin p = {32'd0, a} * {32'd0, b}; {r.hi, r.lo} = acc + p; r.lat = 5; end
                    4'd9: begin p = longint'(sa) * longint'(sb); {r.hi, r.lo} = acc - p; r.lat = 5; end
                    4'd10: begin p = {32'd0, a} * {32'd0, b}; {r.hi, r.lo} = acc - p; r.lat = 5; end
`endif
                    default: ;
                endcase
            end
        end
        return r;
    endfunction

    // One transaction: launch, scramble operands, watch busy/HI/LO every cycle until commit
    task automatic do_op(input string tag, input bit st, input bit vl, input logic [3:0] o,
                         input logic [31:0] a, input logic [31:0] b);
        res_t r;
        r = model(st, vl, o, a, b, m_hi, m_lo);
        @(negedge clk);
        start = st; valid = vl; op = o; A = a; B = b;
        @(negedge clk);
        start = 1'b0; valid = 1'b0; op = 4'd0; A = $urandom; B = $urandom;
        for (int i = 0; i < r.lat; i++) begin
            check({tag, " busy_run"}, {31'd0, busy}, 32'd1);
            check({tag, " hi_hold"}, HI, m_hi);
            check({tag, " lo_hold"}, LO, m_lo);
            @(negedge clk);
        end
        check({tag, " busy_end"}, {31'd0, busy}, 32'd0);
        check({tag, " hi"}, HI, r.hi);
        check({tag, " lo"}, LO, r.lo);
        $display("op=%0d st=%0d vl=%0d A=%h B=%h lat=%0d -> HI=%h LO=%h", o, st, vl, a, b, r.lat, HI, LO);
        m_hi = r.hi; m_lo = r.lo;
    endtask

    initial begin
        res_t        r;
        logic [3:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        reset_n = 1'b0; start = 1'b0; valid = 1'b0; op = 4'd0; A = 32'd0; B = 32'd0;
        repeat (3) @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset hi", HI, 32'd0);
        check("reset lo", LO, 32'd0);
        reset_n = 1'b1;

        do_op("mult_neg", 1, 1, 4'd1, 32'hFFFFFFFE, 32'd3);
        do_op("multu_max", 1, 1, 4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
        do_op("div_neg", 1, 1, 4'd3, 32'hFFFFFFF9, 32'd2);
        do_op("divu_zero", 1, 1, 4'd4, 32'd7, 32'd0);
        do_op("div_ovf", 1, 1, 4'd3, 32'h80000000, 32'hFFFFFFFF);
        do_op("div_zero", 1, 1, 4'd3, 32'h1234, 32'd0);
        do_op("mthi", 0, 1, 4'd5, 32'h12345678, 32'd0);
        do_op("mtlo", 0, 1, 4'd6, 32'h9ABCDEF0, 32'd0);
        do_op("no_valid", 1, 0, 4'd1, 32'd9, 32'd9);
        do_op("op_none", 1, 1, 4'd0, 32'd9, 32'd9);
        do_op("mthi_novalid", 0, 0, 4'd5, 32'h55555555, 32'd0);

        // Requests while busy must be dropped: mtlo, then a new mult
        r = model(1, 1, 4'd3, 32'd100, 32'd7, m_hi, m_lo);
        @(negedge clk);
        start = 1'b1; valid = 1'b1; op = 4'd3; A = 32'd100; B = 32'd7;
        @(negedge clk);
        start = 1'b0; valid = 1'b1; op = 4'd6; A = 32'hDEADBEEF;
        check("busy_ign busy0", {31'd0, busy}, 32'd1);
        @(negedge clk);
        start = 1'b1; valid = 1'b1; op = 4'd1; A = 32'd3; B = 32'd3;
        check("busy_ign lo_hold", LO, m_lo);
        @(negedge clk);
        start = 1'b0; valid = 1'b0; op = 4'd0;
        for (int i = 2; i < r.lat; i++) begin
            check("busy_ign busy", {31'd0, busy}, 32'd1);
            @(negedge clk);
        end
        check("busy_ign busy_end", {31'd0, busy}, 32'd0);
        check("busy_ign hi", HI, r.hi);
        check("busy_ign lo", LO, r.lo);
        $display("busy-ignore div 100/7 -> HI=%h LO=%h", HI, LO);
        m_hi = r.hi; m_lo = r.lo;

        // Asynchronous reset in the middle of a mult
        do_op("pre_rst_hi", 0, 1, 4'd5, 32'hCAFEF00D, 32'd0);
        @(negedge clk);
        start = 1'b1; valid = 1'b1; op = 4'd1; A = 32'd1000; B = 32'd1000;
        @(negedge clk);
        start = 1'b0; valid = 1'b0; op = 4'd0;
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst busy", {31'd0, busy}, 32'd0);
        check("async_rst hi", HI, 32'd0);
        check("async_rst lo", LO, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        check("post_rst busy", {31'd0, busy}, 32'd0);
        check("post_rst hi", HI, 32'd0);
        check("post_rst lo", LO, 32'd0);
        $display("async reset mid-mult -> busy=%0d HI=%h LO=%h", busy, HI, LO);
        m_hi = 32'd0; m_lo = 32'd0;

        do_op("madd_pre_hi", 0, 1, 4'd5, 32'd0, 32'd0);
        do_op("madd_pre_lo", 0, 1, 4'd6, 32'hFFFFFFFF, 32'd0);
        do_op("madd_carry", 1, 1, 4'd7, 32'd1, 32'd1);
        do_op("msubu", 1, 1, 4'd10, 32'd5, 32'd7);

        for (int k = 0; k < 150; k++) begin
            ro = 4'($urandom_range(0, 10));
            ra = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'd0;
                1: rb = $urandom_range(0, 1) ? 32'($urandom_range(1, 9)) : -32'($urandom_range(1, 9));
                default: rb = $urandom;
            endcase
            do_op("rand", $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0, ro, ra, rb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
